// File: rtl/codec_cfg_pkg.sv
// Shared types and defaults for the codec register-init sequencer.
package codec_cfg_pkg;

    localparam int ENTRY_W      = 16;
    localparam int DEF_NUM_REGS = 6;

    localparam logic [7:0] DEF_DEV_ADDR = 8'h34;

    // Entry 0 sits in the least significant word.
    localparam logic [DEF_NUM_REGS*ENTRY_W-1:0] DEF_TABLE = {
        16'h0812, 16'h1001, 16'h0E13, 16'h0C07, 16'h13FF, 16'h0A00
    };

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_REQ      = 3'd2,
        ST_WAIT_ACC = 3'd3,
        ST_WAIT_CMP = 3'd4,
        ST_GAP      = 3'd5,
        ST_FINISH   = 3'd6,
        ST_FAIL     = 3'd7
    } cfg_state_e;

endpackage

// File: rtl/cfg_cycle_timer.sv
// Down-counter shared by the accept timeout and the inter-word gap: load a count,
// step it down, and flag when it is spent (zero) or on its last cycle (<= 1).
module cfg_cycle_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_le1
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_le1  = (r_count <= CNT_W'(1));

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks a parameter table of 16-bit codec register words and issues each as one I2C write,
// with accept timeout, NACK retry, inter-word gap, sticky error and re-run on start.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int                          NUM_REGS   = 6,
    parameter logic [NUM_REGS*ENTRY_W-1:0] INIT_TABLE = DEF_TABLE,
    parameter logic [7:0]                  DEV_ADDR   = DEF_DEV_ADDR,
    parameter int                          MAX_RETRY  = 2,
    parameter int                          GAP_CYCLES = 4,
    parameter int                          TIMEOUT    = 1023,
    parameter bit                          AUTO_START = 1'b1,
    localparam int                         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             busy,
    input  logic             nack,
    output logic             ack_i2c,
    output logic             wr_rd,
    output logic [7:0]       addr,
    output logic [15:0]      data_config,
    output logic [IDX_W-1:0] cfg_index,
    output logic             done_config,
    output logic             error,
    output logic             active
);

    localparam int TMAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam cfg_state_e       RST_ST   = AUTO_START ? ST_ARM : ST_IDLE;

    cfg_state_e       r_state, w_next;
    logic [IDX_W-1:0] r_index, w_index_nxt;
    logic [RTY_W-1:0] r_retry, w_retry_nxt;
    logic             r_ack, r_done, r_error, r_active;
    logic             w_retry_take;
    logic             w_tmr_load, w_tmr_dec, w_tmr_zero, w_tmr_le1;
    logic [CNT_W-1:0] w_tmr_val;
    logic [15:0]      w_data;

    cfg_cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero),
        .o_le1      (w_tmr_le1)
    );

    always_comb begin
        w_next       = r_state;
        w_index_nxt  = r_index;
        w_retry_nxt  = r_retry;
        w_retry_take = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = TMO_LOAD;
        w_tmr_dec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next      = ST_ARM;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            ST_ARM: begin
                if (!busy) w_next = ST_REQ;
            end
            ST_REQ: begin
                w_next     = ST_WAIT_ACC;
                w_tmr_load = 1'b1;
                w_tmr_val  = TMO_LOAD;
            end
            ST_WAIT_ACC: begin
                if (busy)            w_next       = ST_WAIT_CMP;
                else if (w_tmr_zero) w_retry_take = 1'b1;
                else                 w_tmr_dec    = 1'b1;
            end
            // Entering WAIT_CMP required busy high, so busy low here is its falling edge.
            ST_WAIT_CMP: begin
                if (!busy) begin
                    if (nack) begin
                        w_retry_take = 1'b1;
                    end else if (r_index == LAST_IDX) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_next      = ST_GAP;
                        w_index_nxt = r_index + 1'b1;
                        w_retry_nxt = '0;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GAP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_le1) w_next    = ST_ARM;
                else           w_tmr_dec = 1'b1;
            end
            ST_FINISH: w_next = ST_IDLE;
            ST_FAIL:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (w_retry_take) begin
            if (r_retry < RTY_MAX) begin
                w_retry_nxt = r_retry + 1'b1;
                w_next      = ST_ARM;
            end else begin
                w_next = ST_FAIL;
            end
        end
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RST_ST;
            r_index  <= '0;
            r_retry  <= '0;
            r_ack    <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_index  <= w_index_nxt;
            r_retry  <= w_retry_nxt;
            r_ack    <= (w_next == ST_REQ);
            r_done   <= (w_next == ST_FINISH);
            r_active <= (w_next != ST_IDLE) && (w_next != ST_FINISH) && (w_next != ST_FAIL);
            if (w_next == ST_FAIL) begin
                r_error <= 1'b1;
            end else if ((r_state == ST_IDLE) && start) begin
                r_error <= 1'b0;
            end
        end
    end

    always_comb begin
        w_data = INIT_TABLE[ENTRY_W-1:0];
        for (int i = 1; i < NUM_REGS; i++) begin
            if (r_index == IDX_W'(i)) w_data = INIT_TABLE[ENTRY_W*i +: ENTRY_W];
        end
    end

    assign ack_i2c     = r_ack;
    assign wr_rd       = 1'b0;
    assign addr        = DEV_ADDR;
    assign data_config = w_data;
    assign cfg_index   = r_index;
    assign done_config = r_done;
    assign error       = r_error;
    assign active      = r_active;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Randomized bench for codec_cfg_sequencer: an event-schedule model predicts the cycle of every
// ack, done and error from the sequencing rules and a per-entry NACK plan.
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;

    localparam int N    = 6;
    localparam int MAXR = 2;
    localparam int GAP  = 4;
    localparam int TMO  = 15;
    localparam logic [15:0] TBL [N] = '{16'h0A00, 16'h13FF, 16'h0C07, 16'h0E13, 16'h1001, 16'h0812};

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic        clk;
    logic        rst_n, start, busy, nack;
    logic        ack, wr_rd, done, err, act;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  idx;

    logic        rst_b, start_b, busy_b, nack_b;
    logic        ack_b, wr_b, done_b, err_b, act_b;
    logic [7:0]  addr_b;
    logic [15:0] data_b;
    logic [0:0]  idx_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int plan [N];

    codec_cfg_sequencer #(
        .NUM_REGS   (N),
        .DEV_ADDR   (8'h34),
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO),
        .AUTO_START (1'b1)
    ) dut (
        .clk (clk), .reset_n (rst_n), .start (start), .busy (busy), .nack (nack),
        .ack_i2c (ack), .wr_rd (wr_rd), .addr (addr), .data_config (data), .cfg_index (idx),
        .done_config (done), .error (err), .active (act)
    );

    codec_cfg_sequencer #(
        .NUM_REGS   (1),
        .INIT_TABLE (16'h0A00),
        .DEV_ADDR   (8'h34),
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (0),
        .TIMEOUT    (TMO),
        .AUTO_START (1'b1)
    ) dut_b (
        .clk (clk), .reset_n (rst_b), .start (start_b), .busy (busy_b), .nack (nack_b),
        .ack_i2c (ack_b), .wr_rd (wr_b), .addr (addr_b), .data_config (data_b), .cfg_index (idx_b),
        .done_config (done_b), .error (err_b), .active (act_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_plan(input int v);
        for (int i = 0; i < N; i++) plan[i] = v;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},    32'(ack),   32'd0);
        chk({tag, "_done"},   32'(done),  32'd0);
        chk({tag, "_error"},  32'(err),   32'd0);
        chk({tag, "_active"}, 32'(act),   32'd0);
        chk({tag, "_index"},  32'(idx),   32'd0);
        chk({tag, "_data"},   32'(data),  32'h0A00);
        chk({tag, "_addr"},   32'(addr),  32'h34);
        chk({tag, "_wr_rd"},  32'(wr_rd), 32'd0);
    endtask

    // Each state occupies one cycle: after a clean busy fall the next ack follows after
    // max(GAP,1) gap cycles + ARM + REQ; after a NACK, ARM + REQ; an unanswered request
    // spends TIMEOUT+1 cycles waiting, then ARM + REQ.
    task automatic run_seq(input bit from_reset, input bit no_busy, input int abort_idx,
                           input bit poke_start);
        int q [$];
        int att [N];
        int c, cur, term, n_acks, abort_cyc, ev_cyc, ev_kind, act_on, m_rise, m_fall, d, h, n;
        bit fin, m_nack, err_exp, run_on;
        for (int i = 0; i < N; i++) begin
            att[i] = 0;
            n = (no_busy || plan[i] > MAXR) ? MAXR + 1 : plan[i] + 1;
            for (int k = 0; k < n; k++) q.push_back(i);
            if (no_busy || plan[i] > MAXR) break;
        end
        c = cyc; cur = 0; term = -1; n_acks = 0; abort_cyc = -1;
        m_rise = -1; m_fall = -1; m_nack = 1'b0; err_exp = 1'b0; run_on = 1'b0;
        ev_kind = K_ACK; act_on = c + 1;
        if (from_reset) begin
            rst_n  = 1'b1;
            ev_cyc = c + 1;
        end else begin
            start  = 1'b1;
            ev_cyc = c + 2;
        end
        fin = 1'b0;
        for (int it = 0; it < 1500 && !fin; it++) begin
            @(negedge clk);
            c = cyc; start = 1'b0; nack = 1'b0;
            if (c == act_on) run_on = 1'b1;
            if (c == ev_cyc && (ev_kind == K_DONE || ev_kind == K_ERR)) begin
                run_on = 1'b0;
                term   = c;
                if (ev_kind == K_ERR) err_exp = 1'b1;
            end
            chk("ack",    32'(ack),  32'(c == ev_cyc && ev_kind == K_ACK));
            chk("done",   32'(done), 32'(c == ev_cyc && ev_kind == K_DONE));
            chk("error",  32'(err),  32'(err_exp));
            chk("active", 32'(act),  32'(run_on));
            if (c == ev_cyc && ev_kind == K_ACK) begin
                ev_kind = K_NONE;
                if (q.size() == 0) begin
                    chk("ack_beyond_model", 32'd1, 32'd0);
                    fin = 1'b1;
                end else begin
                    cur = q.pop_front();
                    att[cur]++;
                    n_acks++;
                    chk("ack_data",  32'(data),  32'(TBL[cur]));
                    chk("ack_index", 32'(idx),   32'(cur));
                    chk("ack_addr",  32'(addr),  32'h34);
                    chk("ack_wr_rd", 32'(wr_rd), 32'd0);
                    m_nack = no_busy || (att[cur] <= plan[cur]);
                    if (no_busy) begin
                        ev_cyc  = (att[cur] <= MAXR) ? c + TMO + 3 : c + TMO + 2;
                        ev_kind = (att[cur] <= MAXR) ? K_ACK : K_ERR;
                    end else begin
                        d = int'($urandom_range(0, 4));
                        h = int'($urandom_range(2, 5));
                        m_rise = c + d;
                        m_fall = c + d + h;
                    end
                    if (poke_start && n_acks == 3) start = 1'b1;
                    if (cur == abort_idx) abort_cyc = c + 2;
                end
            end
            if (c == m_rise) begin
                busy   = 1'b1;
                m_rise = -1;
            end
            if (c == m_fall) begin
                busy   = 1'b0;
                nack   = m_nack;
                m_fall = -1;
                chk("data_hold", 32'(data), 32'(TBL[cur]));
                if (m_nack) begin
                    ev_cyc  = (att[cur] <= MAXR) ? c + 2 : c + 1;
                    ev_kind = (att[cur] <= MAXR) ? K_ACK : K_ERR;
                end else if (cur == N - 1) begin
                    ev_cyc  = c + 1;
                    ev_kind = K_DONE;
                end else begin
                    ev_cyc  = c + ((GAP > 1) ? GAP : 1) + 2;
                    ev_kind = K_ACK;
                end
            end
            if (c == abort_cyc) begin
                rst_n = 1'b0; busy = 1'b0; nack = 1'b0;
                #1;
                chk_reset_vals("abort");
                fin = 1'b1;
            end
            if (term >= 0 && c >= term + 3) fin = 1'b1;
        end
        if (!fin) chk("run_completes", 32'd0, 32'd1);
        if (abort_idx < 0) chk("acks_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int cb, kb, nb;
        rst_n = 1'b0; start = 1'b0; busy = 1'b0; nack = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; busy_b = 1'b0; nack_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        set_plan(0);
        run_seq(1'b1, 1'b0, -1, 1'b0);

        set_plan(0); plan[2] = 1;
        run_seq(1'b0, 1'b0, -1, 1'b1);

        set_plan(0); plan[1] = 2; plan[3] = 2;
        run_seq(1'b0, 1'b0, -1, 1'b0);

        set_plan(0); plan[4] = 3;
        run_seq(1'b0, 1'b0, -1, 1'b0);

        set_plan(0);
        run_seq(1'b0, 1'b1, -1, 1'b0);

        set_plan(0);
        run_seq(1'b0, 1'b0, 3, 1'b1);
        repeat (2) @(negedge clk);
        chk_reset_vals("held");
        run_seq(1'b1, 1'b0, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_seq(1'b0, 1'b0, -1, (r % 2) == 1);
        end

        // Single-entry table with no gap.
        @(negedge clk);
        chk("b_reset_data", 32'(data_b), 32'h0A00);
        rst_b = 1'b1;
        kb = cyc; cb = -1;
        for (int i = 0; i < 8 && cb < 0; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) cb = cyc;
        end
        chk("b_first_ack_latency", 32'(cb - kb), 32'd1);
        chk("b_ack_data",  32'(data_b), 32'h0A00);
        chk("b_ack_index", 32'(idx_b),  32'd0);
        @(negedge clk);
        busy_b = 1'b1;
        repeat (2) @(negedge clk);
        busy_b = 1'b0;
        kb = cyc;
        @(negedge clk);
        chk("b_done",         32'(done_b),   32'd1);
        chk("b_done_latency", 32'(cyc - kb), 32'd1);
        chk("b_active_drop",  32'(act_b),    32'd0);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) nb++;
            if (done_b === 1'b1) nb++;
        end
        chk("b_no_extra_events", 32'(nb),    32'd0);
        chk("b_error",           32'(err_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
